mac_mc_seq_ctrl: RTL
====================

Name: mac_mc_seq_ctrl

Overview:
- Sequencing controller for the next-generation multi-channel MAC HWPE. It replaces the fixed one-loop microcode with a parametrised hardware job sequencer.
- Driven by the peripheral slave/register file:
  - on job start it runs NB_ITER iterations;
  - each iteration strobes N_CH source streamers, one sink streamer and the engine;
  - it waits for all completions, advances per-channel addresses by a stride, and finally raises a one-cycle done event.

Parameters:
- N_CH, 3, number of source channels (1..8).
- ADDR_W, 32, streamer address width.
- ITER_W, 16, iteration counter width.
- LEN_W, 16, per-iteration stream length width.
- SHIFT_W, 5, engine output shift width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous soft clear (from slave clear).
- start_i  in  1  job trigger pulse.
- nb_iter_m1_i  in  ITER_W  iterations minus one.
- len_m1_i  in  LEN_W  stream length minus one.
- stride_i  in  ADDR_W  per-iteration address increment, all channels.
- base_addr_i  in  N_CH*ADDR_W  per-channel base address.
- sink_base_i  in  ADDR_W  sink base address.
- ch_en_i  in  N_CH  channel enable mask.
- simple_mul_i  in  1  mode: 1 = element-wise multiply, 0 = accumulate.
- shift_i  in  SHIFT_W  engine output shift.
- src_start_o  out  N_CH  per-channel source start strobe.
- src_addr_o  out  N_CH*ADDR_W  per-channel source address.
- sink_start_o  out  1  sink start strobe.
- sink_addr_o  out  ADDR_W  sink address.
- len_o  out  LEN_W+1  length (len_m1+1).
- src_done_i  in  N_CH  per-channel source done pulse.
- sink_done_i  in  1  sink done pulse.
- eng_start_o  out  1  engine start strobe.
- eng_clear_o  out  1  engine accumulator clear strobe.
- eng_simple_mul_o  out  1  latched mode.
- eng_shift_o  out  SHIFT_W  latched shift.
- eng_done_i  in  1  engine done pulse.
- busy_o  out  1  job in progress.
- done_o  out  1  job-complete event pulse.
- iter_o  out  ITER_W  current iteration index.

Behaviour:
- Reset and clear values:
  - On reset, all outputs are 0, FSM is IDLE, and counters, addresses and latched params are 0.
  - clear_i has the same effect as reset but is synchronous, takes priority over every other input, and produces no done_o.
- States: IDLE, START, WAIT, UPDATE, TERM.
- IDLE:
  - busy_o=0.
  - On start_i: latch all job inputs, iter=0, src_addr[c]=base_addr[c], sink_addr=sink_base. Next state START.
- START: one cycle.
  - src_start_o[c]=ch_en[c].
  - sink_start_o=1, eng_start_o=1.
  - eng_clear_o=1 on iter 0 in either mode; in simple_mul mode also on every iteration.
  - Next state WAIT.
- Done tracking:
  - Sticky done flags: src_flag[c], sink_flag, eng_flag.
  - Flags are set by done pulses in START or WAIT.
  - On entering START, flags are reset to src_flag[c]=~ch_en[c] and the rest 0.
- WAIT: when all flags, including this cycle's pulses, are set, go to UPDATE.
- UPDATE: one cycle.
  - If iter==nb_iter_m1, go to TERM.
  - Otherwise: iter+=1; src_addr[c]+=stride; sink_addr+=stride; go to START.
  - Address arithmetic is modulo 2^ADDR_W (wraps silently).
  - Disabled channels' addresses also advance.
- TERM: done_o=1 for one cycle; go to IDLE.
- Latency: start_i at cycle T gives strobes at T+1. The final all-done at cycle D gives UPDATE at D+1, done_o at D+2, and IDLE/busy_o=0 at D+3.
- busy_o=1 in all states except IDLE.
- Latched vs. live inputs: outputs are driven from latched values. Live inputs may change mid-job without effect.
- start_i while busy is ignored.
- Done pulses in IDLE/UPDATE/TERM are ignored.
- ch_en_i==0: the iteration completes on sink and engine done only.
- nb_iter_m1=0: single iteration.
- nb_iter_m1=all-ones: 2^ITER_W iterations; iter_o never overflows, because TERM is taken before the increment.
- len_o width is LEN_W+1, so len_m1=all-ones yields 2^LEN_W without overflow.

Decomposition:
- Package mac_mc_package holds:
  - state enum mac_mc_state_t;
  - job struct mac_mc_job_t (latched params);
  - flags struct mac_mc_flags_t.
- Width parameters are module parameters, so the structs use the package defaults and the module instantiates widths locally where needed.
- Sub-module mac_mc_addrgen: per-channel address register with load(base), step(+stride) and clear; instantiated N_CH+1 times (sources + sink).

Test Plan:
1. N_CH=3, nb_iter_m1=2, stride=0x10, bases 0x100/0x200/0x300, all enabled, dones 5 cycles after start → 3 START strobes; src_addr ch0 = 0x100, 0x110, 0x120; done_o exactly once; busy_o falls 1 cycle after done_o.
2. ch_en=3'b010, dones only from ch1/sink/engine → job completes; src_start_o only ever 3'b010.
3. Done pulses in different cycles (ch0 @+2, eng @+7, sink @+4, ch1 and ch2 in the START cycle) → UPDATE only the cycle after the last pulse.
4. simple_mul=0, nb_iter_m1=3 → eng_clear_o on iter 0 only; simple_mul=1 → eng_clear_o on all 4 iterations.
5. base=0xFFFF_FFF8, stride=0x10, 2 iterations → second address 0x0000_0008.
6. clear_i asserted in WAIT of iter 1 → next cycle IDLE, all outputs 0, no done_o; new start_i runs normally from iter 0. Repeat with rst_ni low mid-job: same reset values.

Source files
------------

// File: rtl/mac_mc_seq_ctrl_pkg.sv
// rtl/mac_mc_seq_ctrl_pkg.sv - shared types for the multi-channel MAC job sequencer
package mac_mc_package;

  localparam int MC_MAX_CH  = 8;
  localparam int MC_ITER_W  = 16;
  localparam int MC_LEN_W   = 16;
  localparam int MC_ADDR_W  = 32;
  localparam int MC_SHIFT_W = 5;

  typedef enum logic [2:0] {
    MC_IDLE   = 3'd0,
    MC_START  = 3'd1,
    MC_WAIT   = 3'd2,
    MC_UPDATE = 3'd3,
    MC_TERM   = 3'd4
  } mac_mc_state_t;

  // Job parameters at default widths; the sequencer re-declares them at its own widths.
  typedef struct packed {
    logic [MC_ITER_W-1:0]  nb_iter_m1;
    logic [MC_LEN_W:0]     len;
    logic [MC_ADDR_W-1:0]  stride;
    logic [MC_MAX_CH-1:0]  ch_en;
    logic                  simple_mul;
    logic [MC_SHIFT_W-1:0] shift;
  } mac_mc_job_t;

  // Source flags are sized for the widest configuration; unused lanes are held at 1.
  typedef struct packed {
    logic [MC_MAX_CH-1:0] src;
    logic                 sink;
    logic                 eng;
  } mac_mc_flags_t;

  function automatic mac_mc_flags_t mc_flags_or(mac_mc_flags_t a, mac_mc_flags_t b);
    return mac_mc_flags_t'(a | b);
  endfunction

  function automatic logic mc_all_done(mac_mc_flags_t f);
    return (&f.src) & f.sink & f.eng;
  endfunction

endpackage

// File: rtl/mac_mc_seq_ctrl_addrgen.sv
// rtl/mac_mc_seq_ctrl_addrgen.sv - per-stream address register with load, stride step and clear
module mac_mc_addrgen #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] r_addr;

  // Wraps modulo 2^ADDR_W by construction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
    end else if (clear_i) begin
      r_addr <= '0;
    end else if (load_i) begin
      r_addr <= base_i;
    end else if (step_i) begin
      r_addr <= r_addr + stride_i;
    end
  end

  assign addr_o = r_addr;

endmodule

// File: rtl/mac_mc_seq_ctrl.sv
// rtl/mac_mc_seq_ctrl.sv - iterating job sequencer driving N_CH sources, one sink and the MAC engine
module mac_mc_seq_ctrl
  import mac_mc_package::*;
#(
  parameter int N_CH    = 3,
  parameter int ADDR_W  = 32,
  parameter int ITER_W  = 16,
  parameter int LEN_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [ITER_W-1:0]      nb_iter_m1_i,
  input  logic [LEN_W-1:0]       len_m1_i,
  input  logic [ADDR_W-1:0]      stride_i,
  input  logic [N_CH*ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0]      sink_base_i,
  input  logic [N_CH-1:0]        ch_en_i,
  input  logic                   simple_mul_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  output logic [N_CH-1:0]        src_start_o,
  output logic [N_CH*ADDR_W-1:0] src_addr_o,
  output logic                   sink_start_o,
  output logic [ADDR_W-1:0]      sink_addr_o,
  output logic [LEN_W:0]         len_o,
  input  logic [N_CH-1:0]        src_done_i,
  input  logic                   sink_done_i,
  output logic                   eng_start_o,
  output logic                   eng_clear_o,
  output logic                   eng_simple_mul_o,
  output logic [SHIFT_W-1:0]     eng_shift_o,
  input  logic                   eng_done_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ITER_W-1:0]      iter_o
);

  typedef struct packed {
    logic [ITER_W-1:0]  nb_iter_m1;
    logic [LEN_W:0]     len;
    logic [ADDR_W-1:0]  stride;
    logic [N_CH-1:0]    ch_en;
    logic               simple_mul;
    logic [SHIFT_W-1:0] shift;
  } job_t;

  mac_mc_state_t r_state;
  mac_mc_state_t w_state_nxt;
  job_t          r_job;
  logic [ITER_W-1:0] r_iter;
  mac_mc_flags_t r_flags;
  mac_mc_flags_t w_flags_base;
  mac_mc_flags_t w_flags_pulse;
  mac_mc_flags_t w_flags_nxt;
  logic          w_all_done;
  logic          w_last_iter;
  logic          w_load;
  logic          w_step;

  assign w_last_iter = (r_iter == r_job.nb_iter_m1);
  assign w_load      = (r_state == MC_IDLE) && start_i;
  assign w_step      = (r_state == MC_UPDATE) && !w_last_iter;

  // In START the flags restart from the enable mask, so pulses landing there already count.
  always_comb begin
    w_flags_pulse                 = '0;
    w_flags_pulse.src[N_CH-1:0]   = src_done_i;
    w_flags_pulse.sink            = sink_done_i;
    w_flags_pulse.eng             = eng_done_i;
    w_flags_base                  = r_flags;
    if (r_state == MC_START) begin
      w_flags_base                = '0;
      w_flags_base.src            = '1;
      w_flags_base.src[N_CH-1:0]  = ~r_job.ch_en;
    end
    w_flags_nxt = mc_flags_or(w_flags_base, w_flags_pulse);
    w_all_done  = mc_all_done(w_flags_nxt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MC_IDLE;
    end else if (clear_i) begin
      r_state <= MC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MC_IDLE:   if (start_i) w_state_nxt = MC_START;
      MC_START:  w_state_nxt = MC_WAIT;
      MC_WAIT:   if (w_all_done) w_state_nxt = MC_UPDATE;
      MC_UPDATE: w_state_nxt = w_last_iter ? MC_TERM : MC_START;
      MC_TERM:   w_state_nxt = MC_IDLE;
      default:   w_state_nxt = MC_IDLE;
    endcase
  end

  always_comb begin
    src_start_o  = '0;
    sink_start_o = 1'b0;
    eng_start_o  = 1'b0;
    eng_clear_o  = 1'b0;
    done_o       = 1'b0;
    busy_o       = (r_state != MC_IDLE);
    case (r_state)
      MC_START: begin
        src_start_o  = r_job.ch_en;
        sink_start_o = 1'b1;
        eng_start_o  = 1'b1;
        eng_clear_o  = (r_iter == '0) | r_job.simple_mul;
      end
      MC_TERM: done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_job   <= '0;
      r_iter  <= '0;
      r_flags <= '0;
    end else if (clear_i) begin
      r_job   <= '0;
      r_iter  <= '0;
      r_flags <= '0;
    end else begin
      if (w_load) begin
        r_job.nb_iter_m1 <= nb_iter_m1_i;
        r_job.len        <= {1'b0, len_m1_i} + {{LEN_W{1'b0}}, 1'b1};
        r_job.stride     <= stride_i;
        r_job.ch_en      <= ch_en_i;
        r_job.simple_mul <= simple_mul_i;
        r_job.shift      <= shift_i;
        r_iter           <= '0;
      end
      if (w_step) begin
        r_iter <= r_iter + {{(ITER_W-1){1'b0}}, 1'b1};
      end
      if ((r_state == MC_START) || (r_state == MC_WAIT)) begin
        r_flags <= w_flags_nxt;
      end
    end
  end

  assign len_o            = r_job.len;
  assign eng_simple_mul_o = r_job.simple_mul;
  assign eng_shift_o      = r_job.shift;
  assign iter_o           = r_iter;

  for (genvar c = 0; c < N_CH; c++) begin : g_src_addr
    mac_mc_addrgen #(
      .ADDR_W(ADDR_W)
    ) u_addrgen (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .load_i  (w_load),
      .step_i  (w_step),
      .base_i  (base_addr_i[c*ADDR_W +: ADDR_W]),
      .stride_i(r_job.stride),
      .addr_o  (src_addr_o[c*ADDR_W +: ADDR_W])
    );
  end

  mac_mc_addrgen #(
    .ADDR_W(ADDR_W)
  ) u_sink_addrgen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .load_i  (w_load),
    .step_i  (w_step),
    .base_i  (sink_base_i),
    .stride_i(r_job.stride),
    .addr_o  (sink_addr_o)
  );

endmodule
